// File: rtl/zoom_line_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : zoom_line_writer_pkg
//  Brief   : State encoding and sizing helpers for the vertical zoom-out
//            line writer.
//  Rev     : 1.0  initial release
// ============================================================================
package zoom_line_writer_pkg;

  // FSM state encoding, explicit 2-bit width
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Default geometry (the block is normally parameterised from above)
  localparam int LARGURA_DEF = 320;
  localparam int ALTURA_DEF  = 240;
  localparam int FATOR_DEF   = 2;

  // $clog2 that never returns 0, so a 1-entry counter still gets a bit
  function automatic int safe_clog2(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

  // Output line width after decimation
  function automatic int calc_w_out(input int largura, input int fator);
    return largura / fator;
  endfunction

  // Output frame height after decimation
  function automatic int calc_h_out(input int altura, input int fator);
    return altura / fator;
  endfunction

endpackage : zoom_line_writer_pkg
`default_nettype wire

// File: rtl/zoom_line_writer.sv
`default_nettype none
// ============================================================================
//  Module  : zoom_line_writer
//  Brief   : Vertical half of a nearest-neighbour zoom-out. Accepts one packed,
//            horizontally decimated line per handshake, keeps every fator-th
//            row and serialises kept rows one pixel per clock into a linear
//            framebuffer write port. Pulses frame_done after the last row.
//  Rev     : 1.0  initial release
// ============================================================================
module zoom_line_writer
  import zoom_line_writer_pkg::*;
#(
  parameter int largura = LARGURA_DEF,
  parameter int altura  = ALTURA_DEF,
  parameter int fator   = FATOR_DEF,
  parameter int ADDR_W  = 17
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    line_valid,
  output logic                                    line_ready,
  input  logic [calc_w_out(largura, fator)*8-1:0] line_in,
  output logic                                    wr_en,
  output logic [ADDR_W-1:0]                       wr_addr,
  output logic [7:0]                              wr_data,
  output logic                                    busy,
  output logic                                    frame_done
);

  // Derived geometry
  localparam int W_OUT  = calc_w_out(largura, fator);
  localparam int H_OUT  = calc_h_out(altura, fator);
  localparam int COL_W  = safe_clog2(W_OUT);
  localparam int ROW_W  = safe_clog2(altura);
  localparam int OROW_W = safe_clog2(H_OUT);
  localparam int LINE_W = W_OUT * 8;

  // fator is a power of two, so "row % fator == 0" is a mask test
  localparam logic [ROW_W-1:0]  FATOR_MASK   = ROW_W'(fator - 1);
  localparam logic [ROW_W-1:0]  LAST_IN_ROW  = ROW_W'(altura - 1);
  localparam logic [COL_W-1:0]  LAST_COL     = COL_W'(W_OUT - 1);
  localparam logic [OROW_W-1:0] LAST_OUT_ROW = OROW_W'(H_OUT - 1);
  localparam logic [ADDR_W-1:0] W_OUT_A      = ADDR_W'(W_OUT);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [ROW_W-1:0]  in_row;
  logic [OROW_W-1:0] out_row;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line_q;
  logic              last_row_q;   // the row being written closes the frame

  logic accept;
  logic row_kept;
  logic row_last;
  logic col_last;

  // Handshake and row classification for the line currently offered
  assign accept   = line_valid && line_ready;
  assign row_kept = (in_row & FATOR_MASK) == '0;
  assign row_last = (in_row == LAST_IN_ROW);
  assign col_last = (col == LAST_COL);

  // State register; reset aborts any write or done cycle immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (row_kept) begin
            state_next = ST_WRITE;
          end else if (row_last) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        if (col_last) begin
          state_next = last_row_q ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; address and data are zero outside WRITE
  always_comb begin
    line_ready = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = 8'h00;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        line_ready = !reset;
      end
      ST_WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = (ADDR_W'(out_row) * W_OUT_A) + ADDR_W'(col);
        wr_data = line_q[{col, 3'b000} +: 8];
      end
      ST_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: begin
        line_ready = 1'b0;
      end
    endcase
  end

  // Row/column counters and the line latch
  always_ff @(posedge clk) begin
    if (reset) begin
      in_row     <= '0;
      out_row    <= '0;
      col        <= '0;
      line_q     <= '0;
      last_row_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_row <= row_last ? '0 : in_row + 1'b1;
            if (row_kept) begin
              line_q     <= line_in;
              col        <= '0;
              last_row_q <= row_last;
            end
          end
        end
        ST_WRITE: begin
          if (col_last) begin
            col <= '0;
            // Wrap explicitly so out_row stays inside the output frame
            if (last_row_q || (out_row == LAST_OUT_ROW)) begin
              out_row <= '0;
            end else begin
              out_row <= out_row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        ST_DONE: begin
          out_row <= '0;
        end
        default: begin
          col <= '0;
        end
      endcase
    end
  end

endmodule : zoom_line_writer
`default_nettype wire

// File: tb/tb_zoom_line_writer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_zoom_line_writer
//  Brief   : Directed self-checking bench for zoom_line_writer with an
//            8x4 input frame decimated by 2 (4x2 output, 4-bit address).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_zoom_line_writer;

  localparam int LARGURA = 8;
  localparam int ALTURA  = 4;
  localparam int FATOR   = 2;
  localparam int ADDR_W  = 4;

  logic        clk;
  logic        reset;
  logic        line_valid;
  logic        line_ready;
  logic [31:0] line_in;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;

  int n_checks;
  int n_errors;

  zoom_line_writer #(
    .largura (LARGURA),
    .altura  (ALTURA),
    .fator   (FATOR),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_in    (line_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a line and let it be taken at the next edge; optionally keep
  // line_valid asserted afterwards
  task automatic accept_line(input logic [31:0] data, input bit hold);
    line_valid = 1'b1;
    line_in    = data;
    check("ready_before_accept", {31'd0, line_ready}, 32'd1);
    tick();
    line_valid = hold;
    line_in    = $urandom;
  endtask

  // Expect four writes of data at base..base+3, then a return to IDLE
  task automatic expect_row(input logic [31:0] data, input logic [3:0] base, input bit hold);
    for (int k = 0; k < 4; k++) begin
      check("wr_en",      {31'd0, wr_en},      32'd1);
      check("wr_addr",    {28'd0, wr_addr},    {28'd0, base + 4'(k)});
      check("wr_data",    {24'd0, wr_data},    {24'd0, data[k*8 +: 8]});
      check("ready_write", {31'd0, line_ready}, 32'd0);
      check("busy_write", {31'd0, busy},       32'd1);
      if (hold) line_in = $urandom;
      tick();
    end
    line_valid = 1'b0;
    check("wr_en_after_row", {31'd0, wr_en},      32'd0);
    check("ready_after_row", {31'd0, line_ready}, 32'd1);
  endtask

  // Expect a dropped row that does not close the frame
  task automatic expect_drop();
    check("drop_wr_en", {31'd0, wr_en},      32'd0);
    check("drop_ready", {31'd0, line_ready}, 32'd1);
    check("drop_done",  {31'd0, frame_done}, 32'd0);
  endtask

  // Expect the one-cycle frame_done after the last row
  task automatic expect_done();
    check("done_pulse", {31'd0, frame_done}, 32'd1);
    check("done_ready", {31'd0, line_ready}, 32'd0);
    check("done_busy",  {31'd0, busy},       32'd1);
    check("done_wr_en", {31'd0, wr_en},      32'd0);
    tick();
    check("done_clear", {31'd0, frame_done}, 32'd0);
    check("done_ready_back", {31'd0, line_ready}, 32'd1);
  endtask

  // Directed sequence
  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    line_valid = 1'b0;
    line_in    = 32'h0;

    // Reset held two cycles
    tick();
    tick();
    check("rst_ready",  {31'd0, line_ready}, 32'd0);
    check("rst_wr_en",  {31'd0, wr_en},      32'd0);
    check("rst_addr",   {28'd0, wr_addr},    32'd0);
    check("rst_data",   {24'd0, wr_data},    32'd0);
    check("rst_busy",   {31'd0, busy},       32'd0);
    check("rst_done",   {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_ready", {31'd0, line_ready}, 32'd1);
    check("rel_wr_en", {31'd0, wr_en},      32'd0);

    // Frame 1: kept, dropped, kept, dropped-last
    accept_line(32'h44332211, 1'b0);
    expect_row(32'h44332211, 4'd0, 1'b0);
    accept_line(32'h99999999, 1'b0);
    expect_drop();
    accept_line(32'hDDCCBBAA, 1'b0);
    expect_row(32'hDDCCBBAA, 4'd4, 1'b0);
    accept_line(32'h12345678, 1'b0);
    expect_done();

    // Frame 2: line_valid held with changing data through WRITE
    accept_line(32'h87654321, 1'b1);
    expect_row(32'h87654321, 4'd0, 1'b1);
    accept_line(32'h55555555, 1'b0);
    expect_drop();
    accept_line(32'h0F0E0D0C, 1'b0);
    expect_row(32'h0F0E0D0C, 4'd4, 1'b0);
    accept_line(32'hAAAAAAAA, 1'b0);
    expect_done();

    // Frame 3: reset after two pixels of row 0
    accept_line(32'h55667788, 1'b0);
    check("abort_px0", {24'd0, wr_data}, 32'h88);
    tick();
    check("abort_px1", {24'd0, wr_data}, 32'h77);
    reset = 1'b1;
    tick();
    check("abort_wr_en", {31'd0, wr_en},      32'd0);
    check("abort_busy",  {31'd0, busy},       32'd0);
    check("abort_ready", {31'd0, line_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort_rel_ready", {31'd0, line_ready}, 32'd1);
    accept_line(32'h0D0C0B0A, 1'b0);
    expect_row(32'h0D0C0B0A, 4'd0, 1'b0);
    accept_line(32'h11111111, 1'b0);
    expect_drop();
    accept_line(32'h04030201, 1'b0);
    expect_row(32'h04030201, 4'd4, 1'b0);
    accept_line(32'h22222222, 1'b0);
    expect_done();

    // Next frame restarts at address 0
    accept_line(32'hC3C2C1C0, 1'b0);
    expect_row(32'hC3C2C1C0, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_zoom_line_writer
`default_nettype wire
